// File: rtl/avl_bus_pkg.sv
// avl_bus_pkg: shared widths, request/response payload structs and skid state encoding
package avl_bus_pkg;
  localparam int AW = 16;
  localparam int DW = 32;
  localparam int BW = DW / 8;
  localparam int CW = 8;
  typedef struct packed {
    logic [AW-1:0] address;
    logic [BW-1:0] byte_en;
    logic read;
    logic write;
    logic [DW-1:0] write_data;
    logic begin_burst_transfer;
    logic [CW-1:0] burst_count;
  } req_t;
  typedef struct packed {
    logic [DW-1:0] read_data;
    logic read_data_valid;
  } rsp_t;
  typedef enum logic [1:0] {EMPTY, ONE, FULL} skid_state_t;
endpackage

// File: rtl/i_avl_bus.sv
// i_avl_bus: Avalon-MM style request/response bundle with master and slave views
interface i_avl_bus;
  import avl_bus_pkg::*;
  logic [AW-1:0] address;
  logic [BW-1:0] byte_en;
  logic read;
  logic write;
  logic [DW-1:0] write_data;
  logic begin_burst_transfer;
  logic [CW-1:0] burst_count;
  logic request_ready;
  logic [DW-1:0] read_data;
  logic read_data_valid;
  logic resp_ready;
  modport master (
    output address, byte_en, read, write, write_data, begin_burst_transfer, burst_count, resp_ready,
    input request_ready, read_data, read_data_valid
  );
  modport slave (
    input address, byte_en, read, write, write_data, begin_burst_transfer, burst_count, resp_ready,
    output request_ready, read_data, read_data_valid
  );
endinterface

// File: rtl/avl_skid_buf.sv
// avl_skid_buf: two-entry skid buffer with registered in_ready and 1-cycle latency
module avl_skid_buf
  import avl_bus_pkg::*;
#(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         in_valid,
  input  logic [W-1:0] in_data,
  output logic         in_ready,
  output logic         out_valid,
  output logic [W-1:0] out_data,
  input  logic         out_ready
);
  skid_state_t state, state_nxt;
  logic rdy_q, acc, drn;
  logic [W-1:0] main_q, skid_q;
  assign in_ready = rdy_q & ~rst;
  assign out_valid = (state != EMPTY) & ~rst;
  assign out_data = main_q;
  assign acc = in_valid & in_ready;
  assign drn = out_valid & out_ready;
  // occupancy follows this cycle's accept and drain
  always_comb begin
    state_nxt = state;
    case (state)
      EMPTY: state_nxt = acc ? ONE : EMPTY;
      ONE: state_nxt = (acc & ~drn) ? FULL : (~acc & drn) ? EMPTY : ONE;
      FULL: state_nxt = drn ? ONE : FULL;
      default: state_nxt = EMPTY;
    endcase
  end
  // state plus ready registered from the next occupancy so it never depends on inputs
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= EMPTY;
      rdy_q <= 1'b0;
    end else begin
      state <= state_nxt;
      rdy_q <= state_nxt != FULL;
    end
  end
  // skid takes every accepted beat; main loads from input, or from skid when draining a full buffer
  always_ff @(posedge clk) begin
    if (acc) skid_q <= in_data;
    if (state == FULL ? drn : acc && (state == EMPTY || drn)) main_q <= state == FULL ? skid_q : in_data;
  end
endmodule

// File: rtl/avl_bus_reg_slice.sv
// avl_bus_reg_slice: registered Avalon request slice; AVL_BUS_REG_SLICE_RSP_EN adds a registered response slice
module avl_bus_reg_slice
  import avl_bus_pkg::*;
(
  input logic      clk,
  input logic      rst,
  i_avl_bus.slave  avl_in,
  i_avl_bus.master avl_out
);
  req_t rq_in, rq_out;
  logic rq_v;
  assign rq_in = {avl_in.address, avl_in.byte_en, avl_in.read, avl_in.write, avl_in.write_data,
                  avl_in.begin_burst_transfer, avl_in.burst_count};
  avl_skid_buf #(.W($bits(req_t))) u_req (
    .clk(clk),
    .rst(rst),
    .in_valid(avl_in.read | avl_in.write),
    .in_data(rq_in),
    .in_ready(avl_in.request_ready),
    .out_valid(rq_v),
    .out_data(rq_out),
    .out_ready(avl_out.request_ready)
  );
  assign avl_out.address = rq_out.address;
  assign avl_out.byte_en = rq_out.byte_en;
  assign avl_out.read = rq_v & rq_out.read;
  assign avl_out.write = rq_v & rq_out.write;
  assign avl_out.write_data = rq_out.write_data;
  assign avl_out.begin_burst_transfer = rq_out.begin_burst_transfer;
  assign avl_out.burst_count = rq_out.burst_count;
`ifdef AVL_BUS_REG_SLICE_RSP_EN
  rsp_t rs_in, rs_out;
  logic rs_v;
  assign rs_in = {avl_out.read_data, avl_out.read_data_valid};
  avl_skid_buf #(.W($bits(rsp_t))) u_rsp (
    .clk(clk),
    .rst(rst),
    .in_valid(avl_out.read_data_valid),
    .in_data(rs_in),
    .in_ready(avl_out.resp_ready),
    .out_valid(rs_v),
    .out_data(rs_out),
    .out_ready(avl_in.resp_ready)
  );
  assign avl_in.read_data = rs_out.read_data;
  assign avl_in.read_data_valid = rs_v & rs_out.read_data_valid;
`else
  assign avl_in.read_data = avl_out.read_data;
  assign avl_in.read_data_valid = avl_out.read_data_valid & ~rst;
  assign avl_out.resp_ready = avl_in.resp_ready;
`endif
endmodule

// File: tb/tb_avl_bus_reg_slice.sv
// tb_avl_bus_reg_slice: randomized scoreboard bench for avl_bus_reg_slice (define AVL_BUS_REG_SLICE_RSP_EN for the registered response path)
module tb_avl_bus_reg_slice;
  import avl_bus_pkg::*;
`ifdef AVL_BUS_REG_SLICE_RSP_EN
  localparam bit RSP = 1'b1;
`else
  localparam bit RSP = 1'b0;
`endif
  typedef struct {
    req_t p;
    int c;
  } ev_t;
  logic clk = 1'b0, rst = 1'b1;
  int cyc = 0, n_cmp = 0, n_err = 0;
  ev_t in_log[$], out_log[$];
  logic [DW-1:0] rin_log[$], rout_log[$];
  int rin_cyc[$], rout_cyc[$];
  req_t src[$];
  i_avl_bus up();
  i_avl_bus dn();
  avl_bus_reg_slice dut (.clk(clk), .rst(rst), .avl_in(up), .avl_out(dn));
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;
  // handshakes seen here complete at the following rising edge; reset drops beats still held
  always @(negedge clk) begin
    ev_t e;
    if (rst) begin
      while (in_log.size() > out_log.size()) in_log.delete(in_log.size() - 1);
    end else begin
      if ((up.read | up.write) & up.request_ready) begin
        e.p = {up.address, up.byte_en, up.read, up.write, up.write_data, up.begin_burst_transfer, up.burst_count};
        e.c = cyc;
        in_log.push_back(e);
      end
      if ((dn.read | dn.write) & dn.request_ready) begin
        e.p = {dn.address, dn.byte_en, dn.read, dn.write, dn.write_data, dn.begin_burst_transfer, dn.burst_count};
        e.c = cyc;
        out_log.push_back(e);
      end
      if (dn.read_data_valid & dn.resp_ready) begin
        rin_log.push_back(dn.read_data);
        rin_cyc.push_back(cyc);
      end
      if (up.read_data_valid & up.resp_ready) begin
        rout_log.push_back(up.read_data);
        rout_cyc.push_back(cyc);
      end
    end
  end

  function automatic req_t rand_beat();
    req_t b;
    b.address = AW'($urandom);
    b.byte_en = BW'($urandom);
    b.read = 1'($urandom_range(0, 1));
    b.write = ~b.read;
    b.write_data = $urandom;
    b.begin_burst_transfer = 1'($urandom_range(0, 1));
    b.burst_count = CW'($urandom);
    return b;
  endfunction

  task automatic set_beat(input req_t b, input logic v);
    up.address = b.address;
    up.byte_en = b.byte_en;
    up.read = v & b.read;
    up.write = v & b.write;
    up.write_data = b.write_data;
    up.begin_burst_transfer = b.begin_burst_transfer;
    up.burst_count = b.burst_count;
  endtask

  // sends src; mode 0 ready, 1 five-cycle stall, 2 toggling, 3 random ready and gaps
  task automatic run_beats(input int mode, output int low_seen);
    int base = in_log.size(), c = 0, idx;
    logic r;
    low_seen = 0;
    while ((in_log.size() - base < src.size() || out_log.size() < in_log.size()) && c < 300) begin
      @(posedge clk);
      #1;
      idx = in_log.size() - base;
      n_cmp++;
      if (up.request_ready !== (in_log.size() - out_log.size() < 2)) begin
        n_err++;
        $display("FAIL ready_occupancy c=%0d: got %b want %b", c, up.request_ready, in_log.size() - out_log.size() < 2);
      end
      if (!up.request_ready) low_seen++;
      dn.request_ready = mode == 0 ? 1'b1 : mode == 1 ? !(c >= 1 && c <= 5) : mode == 2 ? 1'(c % 2) : ($urandom % 3 != 0);
      if (idx < src.size() && (mode != 3 || $urandom % 4 != 0)) set_beat(src[idx], 1'b1);
      else set_beat('0, 1'b0);
      if (mode == 2) begin
        r = up.request_ready;
        #3;
        n_cmp++;
        if (up.request_ready !== r) begin
          n_err++;
          $display("FAIL ready_glitch c=%0d: got %b want %b", c, up.request_ready, r);
        end
      end
      c++;
    end
    if (c >= 300) begin
      n_cmp++;
      n_err++;
      $display("FAIL run_timeout: got %0d cycles want <300", c);
    end
    set_beat('0, 1'b0);
    dn.request_ready = 1'b1;
  endtask

  task automatic check_seq(input string nm, input int ob);
    n_cmp++;
    if (out_log.size() - ob !== src.size()) begin
      n_err++;
      $display("FAIL %s_count: got %0d want %0d", nm, out_log.size() - ob, src.size());
    end
    for (int i = 0; i < src.size() && i < out_log.size() - ob; i++) begin
      n_cmp++;
      if (out_log[ob+i].p !== src[i]) begin
        n_err++;
        $display("FAIL %s_beat%0d: got %h want %h", nm, i, out_log[ob+i].p, src[i]);
      end
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    dn.read_data_valid = 1'b1;
    dn.read_data = 32'hDEAD_BEEF;
    repeat (3) @(posedge clk);
    #1;
    n_cmp++;
    if ({up.request_ready, dn.read, dn.write, up.read_data_valid} !== 4'b0000) begin
      n_err++;
      $display("FAIL reset_outputs: got %b want 0000", {up.request_ready, dn.read, dn.write, up.read_data_valid});
    end
    dn.read_data_valid = 1'b0;
    rst = 1'b0;
    @(posedge clk);
    #1;
    n_cmp++;
    if (up.request_ready !== 1'b1) begin
      n_err++;
      $display("FAIL reset_release_ready: got %b want 1", up.request_ready);
    end
  endtask

  task automatic test_stream();
    int ib = in_log.size(), ob = out_log.size(), low;
    req_t b;
    src.delete();
    for (int i = 0; i < 16; i++) begin
      b = rand_beat();
      b.address = AW'(i);
      b.read = 1'b0;
      b.write = 1'b1;
      b.begin_burst_transfer = i == 0;
      b.burst_count = CW'(16);
      src.push_back(b);
    end
    run_beats(0, low);
    check_seq("stream", ob);
    n_cmp++;
    if (low !== 0) begin
      n_err++;
      $display("FAIL stream_ready_low: got %0d want 0", low);
    end
    for (int i = 0; i < 16 && i < out_log.size() - ob; i++) begin
      n_cmp++;
      if (out_log[ob+i].c - in_log[ib+i].c !== 1 || out_log[ob+i].c !== out_log[ob].c + i) begin
        n_err++;
        $display("FAIL stream_timing%0d: got in %0d out %0d want lag 1 consecutive", i, in_log[ib+i].c, out_log[ob+i].c);
      end
    end
  endtask

  task automatic test_stall();
    int ob = out_log.size(), low;
    req_t b;
    src.delete();
    for (int i = 0; i < 4; i++) begin
      b = rand_beat();
      b.read = 1'b0;
      b.write = 1'b1;
      b.begin_burst_transfer = i == 0;
      b.burst_count = CW'(4);
      src.push_back(b);
    end
    run_beats(1, low);
    check_seq("stall", ob);
    n_cmp++;
    if (low < 1) begin
      n_err++;
      $display("FAIL stall_ready_fell: got %0d low cycles want >0", low);
    end
  endtask

  task automatic test_toggle();
    int ob = out_log.size(), low;
    src.delete();
    for (int i = 0; i < 10; i++) src.push_back(rand_beat());
    run_beats(2, low);
    check_seq("toggle", ob);
  endtask

  task automatic test_random();
    int ob = out_log.size(), low;
    src.delete();
    for (int i = 0; i < 40; i++) src.push_back(rand_beat());
    run_beats(3, low);
    check_seq("random", ob);
  endtask

  task automatic test_reset_mid();
    int ob = out_log.size();
    req_t b;
    b = rand_beat();
    @(posedge clk);
    #1;
    dn.request_ready = 1'b0;
    set_beat(b, 1'b1);
    @(posedge clk);
    #1;
    b = rand_beat();
    set_beat(b, 1'b1);
    @(posedge clk);
    #1;
    b = rand_beat();
    set_beat(b, 1'b1);
    n_cmp++;
    if (up.request_ready !== 1'b0) begin
      n_err++;
      $display("FAIL rstmid_full_ready: got %b want 0", up.request_ready);
    end
    rst = 1'b1;
    dn.request_ready = 1'b1;
    #1;
    n_cmp++;
    if ({dn.read, dn.write, up.request_ready} !== 3'b000) begin
      n_err++;
      $display("FAIL rstmid_during: got %b want 000", {dn.read, dn.write, up.request_ready});
    end
    @(posedge clk);
    #1;
    rst = 1'b0;
    set_beat('0, 1'b0);
    n_cmp++;
    if ({dn.read, dn.write} !== 2'b00) begin
      n_err++;
      $display("FAIL rstmid_after: got %b want 00", {dn.read, dn.write});
    end
    @(posedge clk);
    #1;
    n_cmp++;
    if (up.request_ready !== 1'b1) begin
      n_err++;
      $display("FAIL rstmid_ready: got %b want 1", up.request_ready);
    end
    repeat (3) @(posedge clk);
    #1;
    n_cmp++;
    if (out_log.size() !== ob) begin
      n_err++;
      $display("FAIL rstmid_stale: got %0d beats want %0d", out_log.size(), ob);
    end
  endtask

  task automatic test_resp();
    int b0 = rin_log.size(), u0 = rout_log.size(), c = 0, idx, d;
    while ((rin_log.size() - b0 < 8 || rout_log.size() < rin_log.size()) && c < 100) begin
      @(posedge clk);
      #1;
      idx = rin_log.size() - b0;
`ifdef AVL_BUS_REG_SLICE_RSP_EN
      n_cmp++;
      if (dn.resp_ready !== (rin_log.size() - rout_log.size() < 2)) begin
        n_err++;
        $display("FAIL resp_ready_occupancy c=%0d: got %b want %b", c, dn.resp_ready, rin_log.size() - rout_log.size() < 2);
      end
`endif
      up.resp_ready = !(c == 3 || c == 4);
      dn.read_data_valid = idx < 8;
      dn.read_data = DW'(32'hA0 + idx);
`ifndef AVL_BUS_REG_SLICE_RSP_EN
      #1;
      n_cmp++;
      if (dn.resp_ready !== up.resp_ready || up.read_data_valid !== dn.read_data_valid ||
          (dn.read_data_valid && up.read_data !== dn.read_data)) begin
        n_err++;
        $display("FAIL resp_bypass c=%0d: got %b/%b/%h want %b/%b/%h", c, dn.resp_ready, up.read_data_valid,
                 up.read_data, up.resp_ready, dn.read_data_valid, dn.read_data);
      end
`endif
      c++;
    end
    dn.read_data_valid = 1'b0;
    up.resp_ready = 1'b1;
    n_cmp++;
    if (c >= 100 || rout_log.size() - u0 !== 8) begin
      n_err++;
      $display("FAIL resp_count: got %0d want 8", rout_log.size() - u0);
    end
    for (int i = 0; i < 8 && i < rout_log.size() - u0; i++) begin
      d = rout_cyc[u0+i] - rin_cyc[b0+i];
      n_cmp++;
      if (rout_log[u0+i] !== DW'(32'hA0 + i) || !(RSP ? (i == 0 ? d == 1 : d >= 1) : d == 0)) begin
        n_err++;
        $display("FAIL resp_beat%0d: got %h lag %0d want %h", i, rout_log[u0+i], d, 32'hA0 + i);
      end
    end
  endtask

  initial begin
    set_beat('0, 1'b0);
    dn.request_ready = 1'b1;
    dn.read_data_valid = 1'b0;
    dn.read_data = '0;
    up.resp_ready = 1'b1;
    test_reset();
    test_stream();
    test_stall();
    test_toggle();
    test_reset_mid();
    test_random();
    test_resp();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
